pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 41 ++++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// registered output bundle and the per-state output decode.
package pll_seq_pkg;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_LOCK_CYCLES    = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STAGGER_CYCLES = 64;
  localparam int DEF_MAX_RETRIES    = 3;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SDRAM_REL = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic pll_rst;
    logic sdram_rst;
    logic cam_rst;
    logic ready;
    logic fault;
  } seq_outs_t;

  // Output levels held for the whole time the sequencer sits in a state.
  function automatic seq_outs_t state_outputs(input seq_state_t st);
    seq_outs_t o;
    case (st)
      ST_PLL_RST:   o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ST_WAIT_LOCK: o = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      ST_SDRAM_REL: o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      ST_RUN:       o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ST_FAULT:     o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      default:      o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the refclk domain.
module sync_2ff (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge refclk) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up the PLL, waits for a stable lock, then releases SDRAM and camera
// resets in a staggered order; restarts on lock loss and faults after retries.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       cam_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  localparam int MAX_AB  = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > STAGGER_CYCLES) ? MAX_AB : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int STB_W   = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_ONE      = STB_W'(1);
  localparam logic [STB_W-1:0] STB_LAST     = STB_W'(LOCK_CYCLES - 1);

  logic             locked_s;
  seq_state_t       state_r;
  seq_outs_t        outs_r;
  logic [CNT_W-1:0] cnt_r;
  logic [STB_W-1:0] stable_r;
  logic [1:0]       retry_r;
  logic [7:0]       lol_r;
  seq_state_t       restart_state_s;
  logic [1:0]       restart_retry_s;

  sync_2ff u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .d      (locked),
    .q      (locked_s)
  );

  // Restart target: another PLL pulse while retries remain, otherwise FAULT.
  always_comb begin
    if (retry_r < 2'(MAX_RETRIES)) begin
      restart_state_s = ST_PLL_RST;
      restart_retry_s = retry_r + 2'd1;
    end else begin
      restart_state_s = ST_FAULT;
      restart_retry_s = retry_r;
    end
  end

  // Sequencer FSM; outputs are loaded from the decode of the state being entered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r  <= ST_PLL_RST;
      outs_r   <= state_outputs(ST_PLL_RST);
      cnt_r    <= '0;
      stable_r <= '0;
      retry_r  <= 2'd0;
      lol_r    <= 8'd0;
    end else begin
      case (state_r)
        ST_PLL_RST: begin
          if (cnt_r == RST_LAST) begin
            state_r  <= ST_WAIT_LOCK;
            outs_r   <= state_outputs(ST_WAIT_LOCK);
            cnt_r    <= '0;
            stable_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // A completed stable run outranks a timeout landing on the same cycle.
          if (locked_s && (stable_r == STB_LAST)) begin
            state_r  <= ST_SDRAM_REL;
            outs_r   <= state_outputs(ST_SDRAM_REL);
            cnt_r    <= '0;
            stable_r <= '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r  <= restart_state_s;
            outs_r   <= state_outputs(restart_state_s);
            retry_r  <= restart_retry_s;
            cnt_r    <= '0;
            stable_r <= '0;
          end else begin
            cnt_r    <= cnt_r + CNT_ONE;
            stable_r <= locked_s ? (stable_r + STB_ONE) : '0;
          end
        end
        ST_SDRAM_REL: begin
          if (!locked_s) begin
            state_r <= restart_state_s;
            outs_r  <= state_outputs(restart_state_s);
            retry_r <= restart_retry_s;
            cnt_r   <= '0;
          end else if (cnt_r == STAGGER_LAST) begin
            state_r <= ST_RUN;
            outs_r  <= state_outputs(ST_RUN);
            retry_r <= 2'd0;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_r <= restart_state_s;
            outs_r  <= state_outputs(restart_state_s);
            retry_r <= restart_retry_s;
            cnt_r   <= '0;
            if (lol_r != 8'hFF) begin
              lol_r <= lol_r + 8'd1;
            end else begin
              lol_r <= lol_r;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            state_r <= ST_PLL_RST;
            outs_r  <= state_outputs(ST_PLL_RST);
            retry_r <= 2'd0;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_FAULT;
          end
        end
        default: begin
          state_r  <= ST_PLL_RST;
          outs_r   <= state_outputs(ST_PLL_RST);
          cnt_r    <= '0;
          stable_r <= '0;
        end
      endcase
    end
  end

  assign pll_rst   = outs_r.pll_rst;
  assign sdram_rst = outs_r.sdram_rst;
  assign cam_rst   = outs_r.cam_rst;
  assign ready     = outs_r.ready;
  assign fault     = outs_r.fault;
  assign retry_cnt = retry_r;
  assign lol_cnt   = lol_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a per-cycle vector table for bring-up,
// glitch and lock-loss, plus sequences for timeouts, fault, saturation and resets.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       clear_fault;
  logic       pll_rst;
  logic       sdram_rst;
  logic       cam_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       locked;
    logic       clr;
    logic [4:0] outs;   // {pll_rst, sdram_rst, cam_rst, ready, fault}
    logic [1:0] retry;
    logic [7:0] lol;
  } vec_t;

  localparam int NVEC = 51;
  vec_t tbl [NVEC];

  pll_reset_sequencer #(
    .RST_CYCLES     (4),
    .LOCK_CYCLES    (8),
    .TIMEOUT_CYCLES (32),
    .STAGGER_CYCLES (4),
    .MAX_RETRIES    (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .clear_fault (clear_fault),
    .pll_rst     (pll_rst),
    .sdram_rst   (sdram_rst),
    .cam_rst     (cam_rst),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .lol_cnt     (lol_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [4:0] o, input logic [1:0] rc,
                          input logic [7:0] lc);
    chk({name, "/outs"}, {27'd0, pll_rst, sdram_rst, cam_rst, ready, fault}, {27'd0, o});
    chk({name, "/retry"}, {30'd0, retry_cnt}, {30'd0, rc});
    chk({name, "/lol"}, {24'd0, lol_cnt}, {24'd0, lc});
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic fill(input int lo, input int hi, input logic r, input logic lk, input logic cl,
                      input logic [4:0] o, input logic [1:0] rc, input logic [7:0] lc);
    for (int i = lo; i <= hi; i++) tbl[i] = '{r, lk, cl, o, rc, lc};
  endtask

  // With locked low from a PLL_RST entry at t=0: PLL_RST 4 cycles, WAIT_LOCK 32
  // cycles, three attempts, FAULT entered at t=108 with retry_cnt held at 2.
  task automatic run_timeouts(input string tag);
    int ph;
    logic exp_pll;
    logic exp_flt;
    for (int t = 1; t <= 110; t++) begin
      step();
      exp_flt = (t >= 108);
      ph = (t < 36) ? 0 : ((t < 72) ? 1 : 2);
      exp_pll = exp_flt || ((t - 36 * ph) < 4);
      chk_outs($sformatf("%s_t%0d", tag, t), {exp_pll, 1'b1, 1'b1, 1'b0, exp_flt}, 2'(ph), 8'd0);
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 64; n++) begin
      if (ready === 1'b1) break;
      step();
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    clear_fault = 1'b0;

    // rst lk clr {pll,sdram,cam,ready,fault} retry lol
    fill( 0,  0, 1'b1, 1'b0, 1'b0, 5'b11100, 2'd0, 8'd0);
    fill( 1,  3, 1'b0, 1'b0, 1'b0, 5'b11100, 2'd0, 8'd0);
    fill( 4,  5, 1'b0, 1'b0, 1'b0, 5'b01100, 2'd0, 8'd0);
    fill( 6, 14, 1'b0, 1'b1, 1'b0, 5'b01100, 2'd0, 8'd0);
    fill(15, 18, 1'b0, 1'b1, 1'b0, 5'b00100, 2'd0, 8'd0);
    fill(19, 20, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd0, 8'd0);
    fill(21, 21, 1'b0, 1'b1, 1'b1, 5'b00010, 2'd0, 8'd0);
    fill(22, 23, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd0, 8'd0);
    fill(24, 27, 1'b0, 1'b0, 1'b0, 5'b11100, 2'd1, 8'd1);
    fill(28, 28, 1'b0, 1'b0, 1'b0, 5'b01100, 2'd1, 8'd1);
    fill(29, 33, 1'b0, 1'b1, 1'b0, 5'b01100, 2'd1, 8'd1);
    fill(34, 34, 1'b0, 1'b0, 1'b0, 5'b01100, 2'd1, 8'd1);
    fill(35, 43, 1'b0, 1'b1, 1'b0, 5'b01100, 2'd1, 8'd1);
    fill(44, 47, 1'b0, 1'b1, 1'b0, 5'b00100, 2'd1, 8'd1);
    fill(48, 48, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd0, 8'd1);
    fill(49, 49, 1'b1, 1'b1, 1'b0, 5'b11100, 2'd0, 8'd0);
    fill(50, 50, 1'b0, 1'b1, 1'b0, 5'b11100, 2'd0, 8'd0);

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst;
      locked = tbl[i].locked;
      clear_fault = tbl[i].clr;
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].outs, tbl[i].retry, tbl[i].lol);
    end

    rst = 1'b1;
    locked = 1'b0;
    clear_fault = 1'b0;
    step();
    chk_outs("seqa_reset", 5'b11100, 2'd0, 8'd0);
    rst = 1'b0;
    run_timeouts("timeout1");

    locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_outs("fault_hold", 5'b11101, 2'd2, 8'd0);
    end
    clear_fault = 1'b1;
    locked = 1'b0;
    step();
    chk_outs("clear_fault", 5'b11100, 2'd0, 8'd0);
    clear_fault = 1'b0;
    run_timeouts("timeout2");

    rst = 1'b1;
    step();
    chk_outs("rst_in_fault", 5'b11100, 2'd0, 8'd0);
    rst = 1'b0;

    locked = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      wait_ready();
      locked = 1'b0;
      step();
      locked = 1'b1;
      step();
      chk("lol_pre_restart", {31'd0, ready}, 32'd1);
      step();
      chk_outs($sformatf("lol_event%0d", i), 5'b11100, 2'd1, (i > 255) ? 8'd255 : 8'(i));
    end

    wait_ready();
    chk("lol_sat", {24'd0, lol_cnt}, 32'd255);
    rst = 1'b1;
    step();
    chk_outs("rst_in_run", 5'b11100, 2'd0, 8'd0);
    rst = 1'b0;
    step();
    chk_outs("post_rst", 5'b11100, 2'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
